instr_fetch_unit: RTL and testbench

- Upstream neighbour of the single-cycle control path: owns the PC and fetches 32-bit instructions from instruction memory over a valid/ready request channel plus an in-order response channel.
- Buffers fetched words in a small FIFO and presents Instr plus its PC to decode/control with a valid/ready handshake.
- Accepts a redirect (the PCSrc-qualified branch/jump target) that flushes everything younger.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready request channel and buffers words in a small FIFO.
// Define IFU_BYPASS_EN to let a response go straight to the consumer when the FIFO is empty.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr,
   output logic [31:0] instr_pc
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] pc_align(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [31:0]   fifo_pc   [FIFO_DEPTH];

   logic [CW:0]   credits_used;
   logic [CW-1:0] rsp_dec;
   logic          req_fire;
   logic          rsp_keep;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;

   // Requests are credit-limited so every in-flight word has a FIFO slot waiting for it.
   assign credits_used   = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = rst_n && !redirect && (credits_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_dec        = CW'(imem_rsp_valid);
   assign rsp_keep       = imem_rsp_valid && (discard == '0);
   assign fifo_empty     = (count == '0);

`ifdef IFU_BYPASS_EN
   logic bypass;
   assign bypass      = rst_n && fifo_empty && rsp_keep && !redirect;
   assign instr_valid = !fifo_empty || bypass;
   assign Instr       = !fifo_empty ? fifo_data[rd_ptr] : (bypass ? imem_rsp_data : 32'h0);
   assign instr_pc    = !fifo_empty ? fifo_pc[rd_ptr]   : (bypass ? rsp_pc        : 32'h0);
   assign fifo_push   = rsp_keep && !(bypass && instr_ready);
`else
   assign instr_valid = !fifo_empty;
   assign Instr       = !fifo_empty ? fifo_data[rd_ptr] : 32'h0;
   assign instr_pc    = !fifo_empty ? fifo_pc[rd_ptr]   : 32'h0;
   assign fifo_push   = rsp_keep;
`endif

   assign fifo_pop = instr_valid && instr_ready && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect) begin
         // Everything younger than the redirect is dead: flush the buffer and drop whatever is still in flight.
         fetch_pc    <= pc_align(redirect_pc);
         rsp_pc      <= pc_align(redirect_pc);
         outstanding <= outstanding - rsp_dec;
         discard     <= outstanding - rsp_dec;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (req_fire)
            fetch_pc <= pc_next(fetch_pc);
         if (rsp_keep)
            rsp_pc <= pc_next(rsp_pc);
         outstanding <= outstanding + CW'(req_fire) - rsp_dec;
         if (imem_rsp_valid && (discard != '0))
            discard <= discard - CW'(1);
         if (fifo_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (fifo_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(fifo_push) - CW'(fifo_pop);
      end
   end

   // Buffer storage carries no reset; the outputs are gated by instr_valid instead.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_data[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

   a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with hold control, consumer monitor and run checks.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instr;
   logic [31:0] instr_pc;

   logic        rsp_hold;
   logic [31:0] pend [$];
   logic [31:0] mon_pc [$];
   logic [31:0] mon_ins [$];
   int          checks = 0;
   int          errors = 0;
   int          mark_c, mark_d, mark_f, mark_g;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .Instr(Instr), .instr_pc(instr_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_run(input string tag, input int lo, input int hi, input logic [31:0] base, input int min_len);
      logic [31:0] e;
      chk({tag, "_len_ok"}, 32'(hi - lo >= min_len), 32'd1);
      for (int i = lo; i < hi; i++) begin
         e = base + 32'(4 * (i - lo));
         chk({tag, "_pc"}, mon_pc[i], e);
         chk({tag, "_ins"}, mon_ins[i], 32'hA000_0000 | e);
      end
   endtask

   // Memory: accepts every handshake, answers in order one cycle later unless held.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n)
            pend.delete();
         else if (imem_req_valid && imem_req_ready)
            pend.push_back(imem_req_addr);
         @(posedge clk);
         #1;
         if (rst_n && !rsp_hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hA000_0000 | pend.pop_front();
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // Consumer-side record of every accepted instruction.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && instr_valid && instr_ready && !redirect) begin
            mon_pc.push_back(instr_pc);
            mon_ins.push_back(Instr);
         end
      end
   end

   initial begin
      rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; rsp_hold = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);

      next(); rst_n = 1'b1;
      @(negedge clk);
      chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c0_req_addr", imem_req_addr, 32'h0);
      chk("c0_instr_valid", 32'(instr_valid), 32'd0);
      next(); @(negedge clk);
      chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c1_req_addr", imem_req_addr, 32'h4);
`ifdef IFU_BYPASS_EN
      chk("c1_instr_valid", 32'(instr_valid), 32'd1);
      chk("c1_instr", Instr, 32'hA000_0000);
      chk("c1_instr_pc", instr_pc, 32'h0);
`else
      chk("c1_instr_valid", 32'(instr_valid), 32'd0);
`endif
      next(); @(negedge clk);
      chk("c2_instr_valid", 32'(instr_valid), 32'd1);
`ifdef IFU_BYPASS_EN
      chk("c2_instr", Instr, 32'hA000_0004);
      chk("c2_instr_pc", instr_pc, 32'h4);
      chk("c2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c2_req_addr", imem_req_addr, 32'h8);
`else
      chk("c2_instr", Instr, 32'hA000_0000);
      chk("c2_instr_pc", instr_pc, 32'h0);
      chk("c2_req_valid", 32'(imem_req_valid), 32'd0);
`endif
      repeat (8) next();

      // Consumer stall fills every credit.
      instr_ready = 1'b0;
      repeat (4) next();
      @(negedge clk);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_instr_valid", 32'(instr_valid), 32'd1);
      next(); instr_ready = 1'b1;
      repeat (8) next();

      // Two requests in flight, then redirect to 0x100.
      rsp_hold = 1'b1;
      repeat (5) next();
      @(negedge clk);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
      chk("hold_instr_valid", 32'(instr_valid), 32'd0);
      next();
      redirect = 1'b1; redirect_pc = 32'h0000_0100; rsp_hold = 1'b0;
      mark_c = mon_pc.size();
      @(negedge clk);
      chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
      next(); redirect = 1'b0;
      @(negedge clk);
      chk("redir1_req_addr", imem_req_addr, 32'h0000_0100);
      chk("redir1_req_valid", 32'(imem_req_valid), 32'd0);
      chk("redir1_instr_valid", 32'(instr_valid), 32'd0);
      next(); @(negedge clk);
      chk("redir2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir2_req_addr", imem_req_addr, 32'h0000_0100);
      repeat (10) next();

      // Misaligned target, then memory back-pressure for three cycles.
      redirect = 1'b1; redirect_pc = 32'h0000_0203; imem_req_ready = 1'b0;
      mark_d = mon_pc.size();
      @(negedge clk);
      chk("mis_redir_req_valid", 32'(imem_req_valid), 32'd0);
      next(); redirect = 1'b0;
      @(negedge clk);
      chk("mis_instr_valid", 32'(instr_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            next(); @(negedge clk);
         end
         chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
         chk("bp_req_addr", imem_req_addr, 32'h0000_0200);
      end
      next(); imem_req_ready = 1'b1;
      repeat (10) next();

      // Address wrap past 0xFFFF_FFFC.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      mark_f = mon_pc.size();
      next(); redirect = 1'b0;
      repeat (14) next();
      mark_g = mon_pc.size();

      // Asynchronous reset in the middle of a cycle.
      @(posedge clk); #3; rst_n = 1'b0;
      #1;
      chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("arst_instr_valid", 32'(instr_valid), 32'd0);
      chk("arst_instr", Instr, 32'h0);
      chk("arst_instr_pc", instr_pc, 32'h0);
      chk("arst_req_addr", imem_req_addr, 32'h0);
      repeat (2) @(posedge clk);
      #2; rst_n = 1'b1;
      @(negedge clk);
      chk("rr0_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rr0_req_addr", imem_req_addr, 32'h0);
      next(); @(negedge clk);
      chk("rr1_req_addr", imem_req_addr, 32'h4);
`ifdef IFU_BYPASS_EN
      chk("rr1_instr_valid", 32'(instr_valid), 32'd1);
      chk("rr1_instr", Instr, 32'hA000_0000);
`else
      chk("rr1_instr_valid", 32'(instr_valid), 32'd0);
`endif
      next(); @(negedge clk);
      chk("rr2_instr_pc", instr_pc, 32'h0);

      chk_run("run_start", 0, mark_c, 32'h0000_0000, 6);
      chk_run("run_100", mark_c, mark_d, 32'h0000_0100, 3);
      chk_run("run_200", mark_d, mark_f, 32'h0000_0200, 3);
      chk_run("run_wrap", mark_f, mark_g, 32'hFFFF_FFF8, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
